// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: FSM state encoding and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    // Default reset PC (BASEADDR) used by the fetch stage.
    localparam logic [31:0] FETCH_BASEADDR = 32'h0100_0000;

    // Number of entries in the fetch output buffer.
    localparam logic [1:0] BUF_FULL = 2'd2;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order buffer between instruction fetch and decode.
// ent0_q is always the head; ent1_q holds the younger entry.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_q, ent1_q;
    logic [1:0]   cnt_q;
    logic         pop_eff, push_eff;

    // Ignore a pop of an empty buffer and a push into a full one that is not draining.
    assign pop_eff  = pop && (cnt_q != 2'd0);
    assign push_eff = push && ((cnt_q != BUF_FULL) || pop_eff);
    assign head     = ent0_q;
    assign count    = cnt_q;

    // Storage and occupancy; flush only drops the count, stale data is hidden by count==0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= push_data;
                    else               ent1_q <= push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= push_data;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding memory read at a time, results queued
// into a 2-entry buffer toward decode, with redirect/flush support.
module fetch
    import fetch_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(FETCH_BASEADDR)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    fetch_state_e             state_q, state_d;
    logic [AWIDTH-1:0]        pc_q, pc_d;
    logic                     drop_q, drop_d;
    logic                     push, pop;
    logic [1:0]               count;
    logic [AWIDTH+DWIDTH-1:0] head;

    assign valid_o     = (count != 2'd0);
    assign pop         = valid_o && ready_i;
    assign imem_addr_o = pc_q;
    assign pc_o        = head[AWIDTH+DWIDTH-1:DWIDTH];
    assign insn_o      = head[DWIDTH-1:0];

    fetch_buffer #(.W(AWIDTH + DWIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pc_q, imem_rsp_data_i}),
        .pop       (pop),
        .flush     (redirect_i),
        .head      (head),
        .count     (count)
    );

    // State, PC and drop-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= BASEADDR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state, request strobe and buffer push; a redirect overrides the normal flow.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        imem_req_o = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // A redirect this cycle would make the request target stale, so hold it back.
                if (count < BUF_FULL && !redirect_i) begin
                    imem_req_o = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid_i) begin
                    state_d = S_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        push = 1'b1;
                        pc_d = pc_q + AWIDTH'(4);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_i) begin
            push = 1'b0;
            pc_d = {redirect_pc_i[AWIDTH-1:2], 2'b00};
            // The in-flight read must still retire before a new one is issued,
            // so wait for it and throw its data away.
            if (state_q == S_WAIT && !imem_rsp_valid_i) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = S_REQ;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: behavioural memory, PC-stream scoreboard,
// directed scenarios and a randomized phase.
module tb_fetch;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;

    int n_chk;
    int n_pass;
    int mem_lat;
    int busy_viol;

    fetch #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .pc_o             (pc_o),
        .insn_o           (insn_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    endtask

    task automatic wait_req(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (imem_req_o === 1'b1) ok = 1'b1;
        end
    endtask

    // Memory: answers each request after mem_lat cycles (0 = random 1..4).
    initial begin
        bit          busy;
        int          cnt;
        logic [31:0] addr;
        busy = 1'b0; cnt = 0; addr = '0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        forever begin
            @(negedge clk);
            imem_rsp_valid_i = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = mem_word(addr);
                    busy = 1'b0;
                end
            end
            if (imem_req_o === 1'b1) begin
                if (busy) busy_viol++;
                busy = 1'b1;
                addr = imem_addr_o;
                cnt  = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
            end
        end
    end

    // Scoreboard: delivered instructions must follow the architectural PC stream
    // (reset base, +4 per delivery, redirect target) with data matching memory.
    initial begin
        logic        exp_flush, prev_hold;
        logic [31:0] exp_pc, prev_pc, prev_insn;
        exp_flush = 1'b0; prev_hold = 1'b0;
        exp_pc = BASE; prev_pc = '0; prev_insn = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req",   32'(imem_req_o), 0);
                chk("rst_valid", 32'(valid_o), 0);
                chk("rst_pc",    pc_o, 0);
                chk("rst_insn",  insn_o, 0);
                exp_pc = BASE; exp_flush = 1'b0; prev_hold = 1'b0;
            end else begin
                if (exp_flush) chk("flush_valid", 32'(valid_o), 0);
                if (prev_hold) begin
                    chk("hold_valid", 32'(valid_o), 1);
                    chk("hold_pc",    pc_o, prev_pc);
                    chk("hold_insn",  insn_o, prev_insn);
                end
                if (valid_o && ready_i && !redirect_i) begin
                    chk("seq_pc",   pc_o, exp_pc);
                    chk("seq_insn", insn_o, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
                exp_flush = redirect_i;
                prev_hold = valid_o && !ready_i && !redirect_i;
                prev_pc   = pc_o;
                prev_insn = insn_o;
                if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
            end
        end
    end

    initial begin
        bit          ok;
        int          idx, got;
        logic [31:0] h, p0, p1;
        n_chk = 0; n_pass = 0; busy_viol = 0; mem_lat = 1;
        rst = 1'b1; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;

        // Reset release, first fetches with 1-cycle memory
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); chk("idle_no_req", 32'(imem_req_o), 0);
        @(negedge clk); chk("first_req", 32'(imem_req_o), 1);
                        chk("first_addr", imem_addr_o, 32'h0100_0000);
        @(negedge clk); chk("lat_valid_lo", 32'(valid_o), 0);
        @(negedge clk); chk("lat_valid_hi", 32'(valid_o), 1);
                        chk("first_pc", pc_o, 32'h0100_0000);
        @(negedge clk); chk("thru_gap", 32'(valid_o), 0);
        @(negedge clk); chk("second_valid", 32'(valid_o), 1);
                        chk("second_pc", pc_o, 32'h0100_0004);

        // Decode stalled: buffer fills to two, no more requests
        @(posedge clk); #1 ready_i = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_no_req", 32'(imem_req_o), 0);
            chk("stall_valid", 32'(valid_o), 1);
        end
        h = pc_o;
        @(posedge clk); #1 ready_i = 1'b1;
        @(negedge clk); chk("drain0_pc", pc_o, h);
        @(negedge clk); chk("drain1_valid", 32'(valid_o), 1);
                        chk("drain1_pc", pc_o, h + 32'd4);
        @(negedge clk); chk("drain_empty", 32'(valid_o), 0);

        // Redirect while waiting; late response must be dropped
        @(posedge clk); #1 mem_lat = 4;
        wait_req(20, ok); chk("drop_req_seen", 32'(ok), 1);
        @(posedge clk); #1 redirect_i = 1'b1; redirect_pc_i = 32'h0100_0103;
        @(negedge clk); chk("drop_no_req", 32'(imem_req_o), 0);
        @(posedge clk); #1 redirect_i = 1'b0;
        idx = 0;
        for (int i = 1; i <= 20 && idx == 0; i++) begin
            @(negedge clk);
            if (imem_req_o === 1'b1) idx = i;
        end
        chk("drop_req_cycle", 32'(idx), 4);
        chk("drop_req_addr", imem_addr_o, 32'h0100_0100);

        // Redirect coinciding with a response
        @(posedge clk); #1 ready_i = 1'b0; mem_lat = 3;
        wait_req(20, ok); chk("same_req_seen", 32'(ok), 1);
        repeat (3) @(posedge clk);
        #1 redirect_i = 1'b1; redirect_pc_i = 32'h0200_0010; ready_i = 1'b1; mem_lat = 1;
        @(posedge clk); #1 redirect_i = 1'b0;
        @(negedge clk); chk("same_valid_lo", 32'(valid_o), 0);
                        chk("same_req", 32'(imem_req_o), 1);
                        chk("same_addr", imem_addr_o, 32'h0200_0010);
        @(negedge clk);
        @(negedge clk); chk("same_nodrop_valid", 32'(valid_o), 1);
                        chk("same_nodrop_pc", pc_o, 32'h0200_0010);

        // PC wrap at the top of the address space
        @(posedge clk); #1 redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; mem_lat = 0;
        @(posedge clk); #1 redirect_i = 1'b0;
        got = 0; p0 = '1; p1 = '1;
        for (int i = 0; i < 40 && got < 2; i++) begin
            @(negedge clk);
            if (valid_o && ready_i) begin
                if (got == 0) p0 = pc_o; else p1 = pc_o;
                got++;
            end
        end
        chk("wrap_count", 32'(got), 2);
        chk("wrap_pc0", p0, 32'hFFFF_FFFC);
        chk("wrap_pc1", p1, 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            ready_i       = ($urandom_range(0, 3) != 0);
            redirect_i    = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom;
        end
        @(posedge clk); #1 redirect_i = 1'b0; ready_i = 1'b1; mem_lat = 4;

        // Asynchronous reset in the middle of a wait
        wait_req(20, ok); chk("arst_req_seen", 32'(ok), 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_req",   32'(imem_req_o), 0);
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_pc",    pc_o, 0);
        chk("arst_insn",  insn_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_req(10, ok); chk("arst_new_req", 32'(ok), 1);
        chk("arst_new_addr", imem_addr_o, BASE);
        repeat (30) @(posedge clk);

        chk("one_outstanding", 32'(busy_viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
